// File: rtl/main_scu_bac_int_dispatch.sv
// -----------------------------------------------------------------------------
// main_scu_bac_int_dispatch
//
// Round-robin interrupt dispatcher between the SCU common interrupt handle and
// a single interrupt-consuming master. One pending enabled source is picked,
// its ID is offered on a claim/complete handshake, and on completion a
// one-cycle software-clear pulse is sent back to the handle for that source.
// Only one source is ever in service.
//
// Ports:
//   clk_i          clock
//   reset_i        asynchronous active-high reset
//   int_status_i   enabled interrupt status from the handle (one bit per source)
//   arb_en_i       allows a new selection; service already started continues
//   irq_o          registered request to the master (high while offered)
//   irq_id_o       ID of the selected source (0 when idle or clearing)
//   claim_i        master accepts the offered request (pulse)
//   complete_i     master finished service (pulse)
//   complete_id_i  ID being completed
//   sw_clr_o       one-hot, one-cycle clear pulse to the handle
//   busy_o         high whenever not idle
//   id_err_o       sticky: completion with a wrong ID was seen
//   timeout_o      sticky: service was force-completed by the watchdog
//   err_clr_i      clears id_err_o and timeout_o (a same-cycle set wins)
//
// Optional feature (macro MAIN_SCU_BAC_INT_DISPATCH_TIMEOUT_EN):
//   defined   - a watchdog counts cycles in service; after P_TIMEOUT cycles
//               without a matching completion the source is force-cleared
//               and timeout_o is set.
//   undefined - no watchdog; service waits indefinitely, timeout_o is 0.
// -----------------------------------------------------------------------------
module main_scu_bac_int_dispatch #(
  parameter int unsigned P_SRC_NUM = 32,
  parameter int unsigned P_ID_W    = $clog2(P_SRC_NUM),
  parameter int unsigned P_TIMEOUT = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [P_SRC_NUM-1:0] int_status_i,
  input  logic                 arb_en_i,
  output logic                 irq_o,
  output logic [P_ID_W-1:0]    irq_id_o,
  input  logic                 claim_i,
  input  logic                 complete_i,
  input  logic [P_ID_W-1:0]    complete_id_i,
  output logic [P_SRC_NUM-1:0] sw_clr_o,
  output logic                 busy_o,
  output logic                 id_err_o,
  output logic                 timeout_o,
  input  logic                 err_clr_i
);

  if (P_SRC_NUM < 2 || P_TIMEOUT < 1) begin : g_param_chk
    $error("main_scu_bac_int_dispatch: P_SRC_NUM must be >= 2 and P_TIMEOUT >= 1");
  end

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PEND   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_CLR    = 2'd3;

  localparam logic [P_SRC_NUM-1:0] ONE_HOT0 = {{(P_SRC_NUM-1){1'b0}}, 1'b1};
  localparam logic [P_ID_W-1:0]    LAST_ID  = P_ID_W'(P_SRC_NUM - 1);

  logic [1:0]           state_q,   state_d;
  logic [P_ID_W-1:0]    id_q,      id_d;
  logic [P_ID_W-1:0]    rr_ptr_q,  rr_ptr_d;
  logic [P_ID_W-1:0]    irq_id_q,  irq_id_d;
  logic                 irq_q,     irq_d;
  logic                 busy_q,    busy_d;
  logic                 id_err_q,  id_err_d;
  logic [P_SRC_NUM-1:0] sw_clr_q,  sw_clr_d;
  logic                 id_err_set;

`ifdef MAIN_SCU_BAC_INT_DISPATCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(P_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             to_set;
`endif

  // Round-robin winner: lowest set bit at or above rr_ptr; if none, lowest
  // set bit overall, which is the wrap from P_SRC_NUM-1 back to 0.
  logic [P_SRC_NUM-1:0] upper_mask;
  logic [P_SRC_NUM-1:0] upper_req;
  logic [P_SRC_NUM-1:0] pick_vec;
  logic [P_ID_W-1:0]    win_id;
  logic                 any_req;

  always_comb begin
    upper_mask = {P_SRC_NUM{1'b1}} << rr_ptr_q;
    upper_req  = int_status_i & upper_mask;
    pick_vec   = (upper_req != '0) ? upper_req : int_status_i;
    any_req    = |int_status_i;
    win_id     = '0;
    for (int unsigned k = P_SRC_NUM; k > 0; k--) begin
      if (pick_vec[k-1]) begin
        win_id = P_ID_W'(k - 1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    rr_ptr_d   = rr_ptr_q;
    irq_id_d   = irq_id_q;
    irq_d      = 1'b0;
    sw_clr_d   = '0;
    id_err_set = 1'b0;
`ifdef MAIN_SCU_BAC_INT_DISPATCH_TIMEOUT_EN
    cnt_d      = cnt_q;
    to_set     = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        irq_id_d = '0;
        if (arb_en_i && any_req) begin
          state_d  = S_PEND;
          id_d     = win_id;
          irq_d    = 1'b1;
          irq_id_d = win_id;
        end
      end

      S_PEND: begin
        // A claim beats a withdrawal seen in the same cycle.
        if (claim_i) begin
          state_d = S_ACTIVE;
`ifdef MAIN_SCU_BAC_INT_DISPATCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (!int_status_i[id_q]) begin
          state_d  = S_IDLE;
          irq_id_d = '0;
        end else begin
          irq_d = 1'b1;
        end
      end

      S_ACTIVE: begin
        if (complete_i && (complete_id_i == id_q)) begin
          state_d  = S_CLR;
          irq_id_d = '0;
          sw_clr_d = ONE_HOT0 << id_q;
        end else begin
          id_err_set = complete_i;
`ifdef MAIN_SCU_BAC_INT_DISPATCH_TIMEOUT_EN
          if (cnt_q == CNT_LAST) begin
            state_d  = S_CLR;
            irq_id_d = '0;
            sw_clr_d = ONE_HOT0 << id_q;
            to_set   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end

      S_CLR: begin
        state_d  = S_IDLE;
        irq_id_d = '0;
        rr_ptr_d = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
      end

      default: begin
        state_d  = S_IDLE;
        irq_id_d = '0;
      end
    endcase

    busy_d   = (state_d != S_IDLE);
    id_err_d = id_err_set | (id_err_q & ~err_clr_i);
`ifdef MAIN_SCU_BAC_INT_DISPATCH_TIMEOUT_EN
    timeout_d = to_set | (timeout_q & ~err_clr_i);
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      id_q     <= '0;
      rr_ptr_q <= '0;
      irq_id_q <= '0;
      irq_q    <= 1'b0;
      busy_q   <= 1'b0;
      id_err_q <= 1'b0;
      sw_clr_q <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
      irq_id_q <= irq_id_d;
      irq_q    <= irq_d;
      busy_q   <= busy_d;
      id_err_q <= id_err_d;
      sw_clr_q <= sw_clr_d;
    end
  end

`ifdef MAIN_SCU_BAC_INT_DISPATCH_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign irq_o    = irq_q;
  assign irq_id_o = irq_id_q;
  assign sw_clr_o = sw_clr_q;
  assign busy_o   = busy_q;
  assign id_err_o = id_err_q;

endmodule

// File: tb/tb_main_scu_bac_int_dispatch.sv
module tb_main_scu_bac_int_dispatch;

  localparam int unsigned N  = 32;
  localparam int unsigned W  = 5;
  localparam int unsigned TO = 16;

  logic           clk_i = 1'b0;
  logic           reset_i = 1'b1;
  logic [N-1:0]   int_status_i = '0;
  logic           arb_en_i = 1'b0;
  logic           irq_o;
  logic [W-1:0]   irq_id_o;
  logic           claim_i = 1'b0;
  logic           complete_i = 1'b0;
  logic [W-1:0]   complete_id_i = '0;
  logic [N-1:0]   sw_clr_o;
  logic           busy_o;
  logic           id_err_o;
  logic           timeout_o;
  logic           err_clr_i = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  main_scu_bac_int_dispatch #(
    .P_SRC_NUM (N),
    .P_ID_W    (W),
    .P_TIMEOUT (TO)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .int_status_i  (int_status_i),
    .arb_en_i      (arb_en_i),
    .irq_o         (irq_o),
    .irq_id_o      (irq_id_o),
    .claim_i       (claim_i),
    .complete_i    (complete_i),
    .complete_id_i (complete_id_i),
    .sw_clr_o      (sw_clr_o),
    .busy_o        (busy_o),
    .id_err_o      (id_err_o),
    .timeout_o     (timeout_o),
    .err_clr_i     (err_clr_i)
  );

  // Reference model: phase 0 = nothing offered, 1 = offered to master,
  // 2 = master servicing, 3 = clear pulse going out.
  int          m_phase = 0;
  int unsigned m_id = 0;
  int unsigned m_ptr = 0;
  int unsigned m_cnt = 0;
  bit          m_iderr = 1'b0;
  bit          m_to = 1'b0;

  function automatic bit bitat(logic [N-1:0] v, int unsigned j);
    logic [N-1:0] t;
    t = v >> j;
    return t[0];
  endfunction

  always @(posedge clk_i or posedge reset_i) begin
    bit e_set;
    bit t_set;
    bit found;
    int unsigned j;
    e_set = 1'b0;
    t_set = 1'b0;
    found = 1'b0;
    j = 0;
    if (reset_i) begin
      m_phase = 0; m_id = 0; m_ptr = 0; m_cnt = 0; m_iderr = 1'b0; m_to = 1'b0;
    end else begin
      case (m_phase)
        0: if (arb_en_i) begin
             for (int unsigned k = 0; k < N; k++) begin
               j = (m_ptr + k) % N;
               if (!found && bitat(int_status_i, j)) begin
                 found = 1'b1;
                 m_id = j;
               end
             end
             if (found) m_phase = 1;
           end
        1: if (claim_i) begin
             m_phase = 2;
             m_cnt = 0;
           end else if (!bitat(int_status_i, m_id)) begin
             m_phase = 0;
           end
        2: if (complete_i && int'(complete_id_i) == int'(m_id)) begin
             m_phase = 3;
           end else begin
             if (complete_i) e_set = 1'b1;
`ifdef MAIN_SCU_BAC_INT_DISPATCH_TIMEOUT_EN
             if (m_cnt == TO - 1) begin
               m_phase = 3;
               t_set = 1'b1;
             end else begin
               m_cnt++;
             end
`endif
           end
        default: begin
          m_ptr = (m_id + 1) % N;
          m_phase = 0;
        end
      endcase
      if (e_set) m_iderr = 1'b1; else if (err_clr_i) m_iderr = 1'b0;
      if (t_set) m_to = 1'b1;    else if (err_clr_i) m_to = 1'b0;
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [N-1:0] exp_clr;
    logic [W-1:0] exp_id;
    exp_clr = '0;
    if (m_phase == 3) begin
      exp_clr = 1;
      exp_clr = exp_clr << m_id;
    end
    exp_id = (m_phase == 1 || m_phase == 2) ? W'(m_id) : '0;
    check("m_irq",     irq_o,     (m_phase == 1));
    check("m_irq_id",  irq_id_o,  exp_id);
    check("m_busy",    busy_o,    (m_phase != 0));
    check("m_sw_clr",  sw_clr_o,  exp_clr);
    check("m_id_err",  id_err_o,  m_iderr);
    check("m_timeout", timeout_o, m_to);
  endtask

  task automatic tick();
    @(negedge clk_i);
    compare();
    #1;
  endtask

  task automatic wait_phase(int p, int budget);
    int n;
    n = 0;
    while (m_phase != p && n < budget) begin
      tick();
      n++;
    end
    check("wait_phase_bound", m_phase, p);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    claim_i = 1'b0; complete_i = 1'b0; err_clr_i = 1'b0;
    int_status_i = '0;
    tick();
    reset_i = 1'b0;
  endtask

  task automatic serve(int unsigned id, string tag);
    logic [N-1:0] e;
    e = 1;
    e = e << id;
    wait_phase(1, 40);
    check({tag, "_irq"}, irq_o, 1);
    check({tag, "_id"},  irq_id_o, id);
    claim_i = 1'b1; tick(); claim_i = 1'b0;
    check({tag, "_act_irq"}, irq_o, 0);
    complete_i = 1'b1; complete_id_i = W'(id); tick(); complete_i = 1'b0;
    check({tag, "_clr"}, sw_clr_o, e);
    tick();
    check({tag, "_clr_end"}, sw_clr_o, 0);
  endtask

  initial begin
    // reset state
    tick(); tick();
    check("rst_irq", irq_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_clr", sw_clr_o, 0);
    check("rst_id", irq_id_o, 0);
    reset_i = 1'b0;

    // 1: round-robin wrap
    arb_en_i = 1'b1;
    int_status_i = 32'h0000_0011;
    tick();
    check("t1_latency_irq", irq_o, 1);
    serve(0, "t1a");
    serve(4, "t1b");
    serve(0, "t1c");
    int_status_i = '0;
    tick();

    // 2: withdrawal before claim
    do_reset();
    int_status_i = 32'h80;
    tick();
    check("t2_irq", irq_o, 1);
    check("t2_id", irq_id_o, 7);
    int_status_i = '0;
    tick();
    check("t2_wd_irq", irq_o, 0);
    check("t2_wd_busy", busy_o, 0);
    check("t2_wd_clr", sw_clr_o, 0);
    int_status_i = 32'h180;
    tick();
    check("t2_ptr_kept", irq_id_o, 7);
    serve(7, "t2");
    int_status_i = '0;
    tick();

    // 3: wrong completion ID
    do_reset();
    int_status_i = 32'h8;
    tick();
    claim_i = 1'b1; tick(); claim_i = 1'b0;
    complete_i = 1'b1; complete_id_i = 5; tick(); complete_i = 1'b0;
    check("t3_err", id_err_o, 1);
    check("t3_busy", busy_o, 1);
    check("t3_noclr", sw_clr_o, 0);
    complete_i = 1'b1; complete_id_i = 3; tick(); complete_i = 1'b0;
    check("t3_clr", sw_clr_o, 32'h8);
    tick();
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    check("t3_err_clr", id_err_o, 0);
    wait_phase(1, 10);
    claim_i = 1'b1; tick(); claim_i = 1'b0;
    complete_i = 1'b1; complete_id_i = 5; err_clr_i = 1'b1; tick();
    complete_i = 1'b0; err_clr_i = 1'b0;
    check("t3_set_wins", id_err_o, 1);
    complete_i = 1'b1; complete_id_i = 3; tick(); complete_i = 1'b0;
    int_status_i = '0;
    tick(); tick();

    // 4: claim and withdrawal together
    do_reset();
    int_status_i = 32'h4;
    tick();
    claim_i = 1'b1; int_status_i = '0; tick(); claim_i = 1'b0;
    check("t4_busy", busy_o, 1);
    check("t4_irq", irq_o, 0);
    check("t4_id", irq_id_o, 2);
    complete_i = 1'b1; complete_id_i = 2; tick(); complete_i = 1'b0;
    check("t4_clr", sw_clr_o, 32'h4);
    tick();

    // 5: reset during service
    do_reset();
    int_status_i = 32'h2;
    tick();
    claim_i = 1'b1; tick(); claim_i = 1'b0;
    reset_i = 1'b1;
    #1;
    check("t5_irq", irq_o, 0);
    check("t5_busy", busy_o, 0);
    check("t5_clr", sw_clr_o, 0);
    tick();
    reset_i = 1'b0;
    tick();
    check("t5_regrant_irq", irq_o, 1);
    check("t5_regrant_id", irq_id_o, 1);
    serve(1, "t5");
    int_status_i = '0;
    tick();

    // 6: watchdog
    do_reset();
    int_status_i = 32'h40;
    tick();
    claim_i = 1'b1; tick(); claim_i = 1'b0;
`ifdef MAIN_SCU_BAC_INT_DISPATCH_TIMEOUT_EN
    for (int i = 0; i < int'(TO) - 1; i++) begin
      tick();
      check("t6_wait_clr", sw_clr_o, 0);
      check("t6_wait_busy", busy_o, 1);
    end
    tick();
    check("t6_to_clr", sw_clr_o, 32'h40);
    check("t6_to_flag", timeout_o, 1);
    tick();
    check("t6_to_sticky", timeout_o, 1);
    int_status_i = '0;
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    check("t6_to_cleared", timeout_o, 0);
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      check("t6_no_to", timeout_o, 0);
      check("t6_hold_busy", busy_o, 1);
    end
    complete_i = 1'b1; complete_id_i = 6; tick(); complete_i = 1'b0;
    check("t6_clr", sw_clr_o, 32'h40);
    int_status_i = '0;
    tick();
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) int_status_i = $urandom & $urandom & $urandom;
      else if ($urandom_range(0, 9) == 0) int_status_i = int_status_i ^ (32'h1 << $urandom_range(0, N - 1));
      arb_en_i      = ($urandom_range(0, 7) != 0);
      claim_i       = ($urandom_range(0, 3) == 0);
      complete_i    = ($urandom_range(0, 4) == 0);
      complete_id_i = ($urandom_range(0, 3) != 0) ? W'(m_id) : W'($urandom_range(0, N - 1));
      err_clr_i     = ($urandom_range(0, 15) == 0);
      reset_i       = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset_i = 1'b0;
    claim_i = 1'b0; complete_i = 1'b0; err_clr_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
